// File: rtl/ufloat_add_pipe.sv
// ufloat_add_pipe: 3-stage pipelined adder for unsigned hidden-one floats
// with alignment, normalisation, round-half-up on the guard bit and saturation.
module ufloat_add_pipe #(
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW-1:0]  a,
  input  logic [EW+MW-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW-1:0]  c,
  output logic              ovf
);
  localparam int W = EW + MW;
  logic en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [EW:0] e1_q, e1_d, e2_q, e2_d, er;
  logic [MW+1:0] ml_q, ml_d, ms_q, ms_d;
  logic [MW-1:0] m2_q, m2_d;
  logic g2_q, g2_d;
  logic [W-1:0] c_q, c_d;
  logic ovf_q, ovf_d;
  logic [EW-1:0] ea, eb, d;
  logic a_big;
  logic [MW+2:0] sum;
  logic [MW:0] mr;
  always_comb begin
    en = !v3_q || out_ready;
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
    ea = a[W-1:MW];
    eb = b[W-1:MW];
    a_big = ea >= eb;
    d = a_big ? ea - eb : eb - ea;
    e1_d = {1'b0, a_big ? ea : eb};
    ml_d = {1'b1, a_big ? a[MW-1:0] : b[MW-1:0], 1'b0};
    ms_d = {1'b1, a_big ? b[MW-1:0] : a[MW-1:0], 1'b0} >> d;
    sum = {1'b0, ml_q} + {1'b0, ms_q};
    m2_d = sum[MW+2] ? sum[MW+1:2] : sum[MW:1];
    g2_d = sum[MW+2] ? sum[1] : sum[0];
    e2_d = e1_q + {{EW{1'b0}}, sum[MW+2]};
    // a rounding carry out of the mantissa wraps it to zero and bumps the exponent
    mr = {1'b0, m2_q} + {{MW{1'b0}}, g2_q};
    er = e2_q + {{EW{1'b0}}, mr[MW]};
    ovf_d = er[EW];
    c_d = er[EW] ? '1 : {er[EW-1:0], mr[MW-1:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      e1_q <= '0;
      ml_q <= '0;
      ms_q <= '0;
      e2_q <= '0;
      m2_q <= '0;
      g2_q <= 1'b0;
      c_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      e1_q <= e1_d;
      ml_q <= ml_d;
      ms_q <= ms_d;
      e2_q <= e2_d;
      m2_q <= m2_d;
      g2_q <= g2_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = en;
  assign out_valid = v3_q;
  assign c = c_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_ufloat_add_pipe.sv
// tb_ufloat_add_pipe: directed table, stall/reset sequences and random traffic
// checked against an integer-arithmetic model of the float sum.
module tb_ufloat_add_pipe;
  localparam int EW = 3;
  localparam int MW = 4;
  localparam int W = EW + MW;
  typedef struct {logic [W-1:0] c; logic ovf;} exp_t;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; logic ovf;} vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [W-1:0] a, b, c;
  int errors = 0;
  int checks = 0;
  int nres = 0;
  exp_t q[$];
  logic stall_q = 1'b0;
  logic [W-1:0] hc;
  logic hovf;
  ufloat_add_pipe #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask
  // Sum computed in units of 2^(eL-MW-1); half-up rounding by add-then-shift.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ex, ey, sx, sy, el, d, sum, k, e, r;
    exp_t o;
    ex = int'(x) >> MW;
    ey = int'(y) >> MW;
    sx = (1 << MW) + (int'(x) & ((1 << MW) - 1));
    sy = (1 << MW) + (int'(y) & ((1 << MW) - 1));
    if (ex >= ey) begin el = ex; d = ex - ey; sum = 2 * sx + ((2 * sy) >> d); end
    else begin el = ey; d = ey - ex; sum = 2 * sy + ((2 * sx) >> d); end
    k = (sum >= (1 << (MW + 2))) ? 2 : 1;
    e = el + k - 1;
    r = (sum + (1 << (k - 1))) >> k;
    if (r == (1 << (MW + 1))) begin r = r >> 1; e++; end
    if (e >= (1 << EW)) begin o.c = '1; o.ovf = 1'b1; end
    else begin o.c = W'((e << MW) + r - (1 << MW)); o.ovf = 1'b0; end
    return o;
  endfunction
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ordy);
    exp_t e;
    if (stall_q) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_c", c, hc);
      chk("hold_ovf", ovf, hovf);
    end
    in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (in_valid && in_ready) q.push_back(model(a, b));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious result: got c=%0h with none expected", c);
      end else begin
        e = q.pop_front();
        chk("sb_c", c, e.c);
        chk("sb_ovf", ovf, e.ovf);
        nres++;
      end
    end
    stall_q = out_valid && !out_ready;
    hc = c; hovf = ovf;
    @(negedge clk);
  endtask
  vec_t tbl[7];
  logic [7:0] pat;
  int sent, n0;
  initial begin
    tbl[0] = '{7'b100_0001, 7'b100_1000, 7'b101_0101, 1'b0};
    tbl[1] = '{7'b100_0000, 7'b100_1000, 7'b101_0100, 1'b0};
    tbl[2] = '{7'b101_0000, 7'b011_0000, 7'b101_0100, 1'b0};
    tbl[3] = '{7'b011_0000, 7'b101_0000, 7'b101_0100, 1'b0};
    tbl[4] = '{7'b101_1111, 7'b000_0000, 7'b110_0000, 1'b0};
    tbl[5] = '{7'b111_0000, 7'b000_1111, 7'b111_0000, 1'b0};
    tbl[6] = '{7'b111_1111, 7'b111_1111, 7'b111_1111, 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, 1'b1);
      chk("lat1", out_valid, 0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("lat2", out_valid, 0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("lat3", out_valid, 1);
      chk("tbl_c", c, tbl[i].c);
      chk("tbl_ovf", ovf, tbl[i].ovf);
    end
    cycle(1'b0, '0, '0, 1'b1);
    // overflow result held under backpressure
    cycle(1'b1, 7'h7f, 7'h7f, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_inready_low", in_ready, 0);
    cycle(1'b0, '0, '0, 1'b0);
    chk("ovf_hold_c", c, 7'h7f);
    chk("ovf_hold_f", ovf, 1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    chk("ovf_drained", out_valid, 0);
    // 8-pair stream with out_ready pattern 1,0,0,1,0,1,1,1
    pat = 8'b1110_1001;
    sent = 0; n0 = nres;
    for (int t = 0; t < 40 && (sent < 8 || q.size() != 0); t++) begin
      logic ordy;
      logic [W-1:0] ra, rb;
      ordy = (t < 8) ? pat[t] : 1'b1;
      ra = W'($urandom); rb = W'($urandom);
      in_valid = sent < 8; out_ready = ordy;
      #1;
      if (in_valid && in_ready) sent++;
      cycle(sent < 8 || (in_valid && !in_ready) ? 1'b1 : (in_valid && in_ready && sent == 8), ra, rb, ordy);
    end
    chk("stream_count", nres - n0, 8);
    chk("stream_empty", q.size(), 0);
    // reset with results in flight
    cycle(1'b1, 7'b100_0001, 7'b100_1000, 1'b1);
    cycle(1'b1, 7'b101_0000, 7'b011_0000, 1'b1);
    cycle(1'b1, 7'b111_1111, 7'b111_1111, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_c", c, 0);
    chk("mid_rst_ovf", ovf, 0);
    q.delete(); stall_q = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      cycle(1'b0, '0, '0, 1'b1);
      chk("no_stale", out_valid, 0);
    end
    cycle(1'b1, 7'b101_1111, 7'b000_0000, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    chk("post_rst_lat2", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_c", c, 7'b110_0000);
    cycle(1'b0, '0, '0, 1'b1);
    // random traffic against the model
    for (int t = 0; t < 400; t++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    repeat (6) cycle(1'b0, '0, '0, 1'b1);
    chk("rand_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
